// File: rtl/mips_alu.sv
// Execute-stage ALU: add/sub/and/or/logical shifts with one cycle of latency.
// Result, zero and overflow are registered and held while in_valid is low.
module mips_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [5:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid
);

    typedef enum logic [5:0] {
        OP_ADD = 6'd27,
        OP_SUB = 6'd28,
        OP_AND = 6'd29,
        OP_OR  = 6'd30,
        OP_SRL = 6'd31,
        OP_SLL = 6'd32
    } op_e;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;
    logic             zero_q;
    logic             valid_q;

    assign sum  = src1 + src2;
    assign diff = src1 - src2;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        result_d   = '0;
        overflow_d = 1'b0;
        case (operation)
            OP_ADD: begin
                result_d   = sum;
                overflow_d = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                             (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                result_d   = diff;
                overflow_d = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                             (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_AND:  result_d = src1 & src2;
            OP_OR:   result_d = src1 | src2;
            OP_SRL:  result_d = src1 >> shamt;
            OP_SLL:  result_d = src1 << shamt;
            default: result_d = '0;
        endcase
    end

    // Reset values describe an all-zero result, so zero comes up asserted.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                zero_q     <= (result_d == '0);
                overflow_q <= overflow_d;
            end
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases then randomized ops
// against an arithmetic reference model.
module tb_mips_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  shamt;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [5:0]  operation;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_res  = 32'h0;
    logic        exp_zero = 1'b1;
    logic        exp_ovf  = 1'b0;

    always #5 clk = ~clk;

    mips_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .shamt     (shamt),
        .src1      (src1),
        .src2      (src2),
        .operation (operation),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: signed overflow judged by whether the true signed result fits in 32 bits.
    task automatic ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, output logic [31:0] res, output logic ovf);
        longint sa, sb, full;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 32'h0;
        ovf = 1'b0;
        case (op)
            6'd27: begin
                full = sa + sb;
                res  = a + b;
                ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            6'd28: begin
                full = sa - sb;
                res  = a - b;
                ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            6'd29: res = a & b;
            6'd30: res = a | b;
            6'd31: res = a >> sh;
            6'd32: res = a << sh;
            default: res = 32'h0;
        endcase
    endtask

    task automatic run_cycle(input string tag, input logic v, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        o;
        @(negedge clk);
        in_valid  = v;
        operation = op;
        src1      = a;
        src2      = b;
        shamt     = sh;
        if (v) begin
            ref_op(op, a, b, sh, r, o);
            exp_res  = r;
            exp_zero = (r == 32'h0);
            exp_ovf  = o;
        end
        @(posedge clk);
        #1;
        check({tag, ".result"},    result,    exp_res);
        check({tag, ".zero"},      zero,      exp_zero);
        check({tag, ".overflow"},  overflow,  exp_ovf);
        check({tag, ".out_valid"}, out_valid, v);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        shamt     = '0;
        src1      = '0;
        src2      = '0;
        operation = '0;
        #12;
        check("reset.result",    result,    32'h0);
        check("reset.zero",      zero,      1'b1);
        check("reset.overflow",  overflow,  1'b0);
        check("reset.out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_cycle("add_1_3",   1'b1, 6'd27, 32'd1,   32'd3,   5'd7);
        run_cycle("sub_87_87", 1'b1, 6'd28, 32'd87,  32'd87,  5'd0);
        run_cycle("and",       1'b1, 6'd29, 32'd123, 32'd456, 5'd4);
        run_cycle("or",        1'b1, 6'd30, 32'd123, 32'd456, 5'd4);
        run_cycle("srl",       1'b1, 6'd31, 32'd10,  32'hFFFF_FFFF, 5'd3);
        run_cycle("sll",       1'b1, 6'd32, 32'd10,  32'hFFFF_FFFF, 5'd3);
        run_cycle("srl_sh0",   1'b1, 6'd31, 32'hDEAD_BEEF, 32'd0, 5'd0);
        run_cycle("add_ovf",   1'b1, 6'd27, 32'h7FFF_FFFF, 32'd1, 5'd0);
        run_cycle("hold",      1'b0, 6'd30, 32'h1234_5678, 32'd9, 5'd1);
        run_cycle("sub_ovf",   1'b1, 6'd28, 32'h8000_0000, 32'd1, 5'd0);
        run_cycle("add_wrap",  1'b1, 6'd27, 32'hFFFF_FFFF, 32'd1, 5'd0);
        run_cycle("sub_wrap",  1'b1, 6'd28, 32'd0, 32'd1, 5'd0);
        run_cycle("op0",       1'b1, 6'd0,  32'd55, 32'd66, 5'd2);
        run_cycle("op63",      1'b1, 6'd63, 32'd55, 32'd66, 5'd2);

        // Asynchronous reset between edges must clear outputs immediately.
        run_cycle("pre_rst",   1'b1, 6'd27, 32'd40, 32'd2, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.result",    result,    32'h0);
        check("async_rst.zero",      zero,      1'b1);
        check("async_rst.out_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 6'd30;
        src1      = 32'hFFFF_0000;
        src2      = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        check("rst_discard.result",    result,    32'h0);
        check("rst_discard.out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_res  = 32'h0;
        exp_zero = 1'b1;
        exp_ovf  = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 9))
                0: op = 6'd0;
                1: op = 6'd63;
                2: op = 6'($urandom);
                default: op = 6'($urandom_range(27, 32));
            endcase
            run_cycle($sformatf("rand%0d_op%0d", i, op), ($urandom_range(0, 4) != 0),
                      op, pick_operand(), pick_operand(), 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
